// File: rtl/bus_pkg.sv
// Shared bus definitions for the serial system bus.
// Holds the arbiter state encoding and the width constants shared with
// slave_in_port (slave ID, address, data, burst length).
package bus_pkg;

  localparam int unsigned SLAVE_ID_W = 2;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BURST_W    = 13;

  // Arbiter connection phases
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SID     = 2'd1,
    CONNECT = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between master 1 and master 2.
// Ports:
//   clk, reset  : clock, async active-high reset
//   req1, req2  : master request levels
//   advance     : commit the current pick as last_winner
//   winner_c    : combinational pick, 0 = master 1, 1 = master 2
//   any_req_c   : combinational, at least one request present
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic req2,
  input  logic advance,
  output logic winner_c,
  output logic any_req_c
);

  logic last_winner_q;
  logic last_winner_d;

  // On a tie the master that did not win last time is picked
  always_comb begin
    any_req_c = req1 | req2;
    if (req1 && req2) begin
      winner_c = ~last_winner_q;
    end else begin
      winner_c = req2;
    end
    last_winner_d = last_winner_q;
    if (advance && any_req_c) begin
      last_winner_d = winner_c;
    end
  end

  // Reset value favours master 1 on the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner_q <= 1'b1;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serial system bus arbiter: grants one of two masters round-robin, captures
// the serial slave ID (LSB-first) from the granted master, drives the bus mux
// and one-hot slave select, and holds the connection until tx_done or timeout.
// Ports:
//   clk, reset         : clock, async active-high reset
//   m1_req, m2_req     : master request levels
//   m_sid, m_sid_valid : serial slave-ID bit and qualifier from granted master
//   tx_done            : one-cycle transaction-complete pulse
//   m1_grant, m2_grant : registered grants
//   msel               : bus mux select (0 = master 1, 1 = master 2)
//   slave_sel          : one-hot slave select, asserted in CONNECT only
//   bus_busy           : high whenever the arbiter is not idle
//   timeout            : one-cycle pulse on forced release
module bus_arbiter #(
  parameter int unsigned SLAVE_ID_W = bus_pkg::SLAVE_ID_W,
  parameter logic [11:0] TIMEOUT    = 12'd4095
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          m1_req,
  input  logic                          m2_req,
  input  logic                          m_sid,
  input  logic                          m_sid_valid,
  input  logic                          tx_done,
  output logic                          m1_grant,
  output logic                          m2_grant,
  output logic                          msel,
  output logic [(1<<SLAVE_ID_W)-1:0]    slave_sel,
  output logic                          bus_busy,
  output logic                          timeout
);

  localparam int unsigned SEL_W = 1 << SLAVE_ID_W;
  localparam int unsigned CNT_W = $clog2(SLAVE_ID_W + 1);
  localparam int unsigned TO_W  = 12;

  bus_pkg::state_e         state_q, state_d;
  logic [SLAVE_ID_W-1:0]   sid_q, sid_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    m1_grant_q, m1_grant_d;
  logic                    m2_grant_q, m2_grant_d;
  logic                    msel_q, msel_d;
  logic [SEL_W-1:0]        slave_sel_q, slave_sel_d;
  logic                    bus_busy_q, bus_busy_d;
  logic                    timeout_q, timeout_d;

  logic                    arb_advance;
  logic                    winner_c;
  logic                    any_req_c;
  logic                    owner_req;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req1     (m1_req),
    .req2     (m2_req),
    .advance  (arb_advance),
    .winner_c (winner_c),
    .any_req_c(any_req_c)
  );

  // Next state, datapath and output values (outputs follow the next state)
  always_comb begin
    state_d     = state_q;
    sid_d       = sid_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    msel_d      = msel_q;
    timeout_d   = 1'b0;
    arb_advance = 1'b0;
    owner_req   = msel_q ? m2_req : m1_req;

    case (state_q)
      bus_pkg::IDLE: begin
        if (any_req_c) begin
          arb_advance = 1'b1;
          msel_d      = winner_c;
          sid_d       = '0;
          bit_cnt_d   = '0;
          state_d     = bus_pkg::SID;
        end
      end

      bus_pkg::SID: begin
        // A dropped request aborts the ID phase before any slave is selected
        if (!owner_req) begin
          sid_d     = '0;
          bit_cnt_d = '0;
          state_d   = bus_pkg::IDLE;
        end else if (m_sid_valid) begin
          for (int unsigned i = 0; i < SLAVE_ID_W; i++) begin
            if (bit_cnt_q == CNT_W'(i)) begin
              sid_d[i] = m_sid;
            end
          end
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(SLAVE_ID_W - 1)) begin
            to_cnt_d = '0;
            state_d  = bus_pkg::CONNECT;
          end
        end
      end

      bus_pkg::CONNECT: begin
        // tx_done takes priority over an expiring timeout
        if (tx_done) begin
          state_d = bus_pkg::RELEASE;
        end else if (to_cnt_q == (TIMEOUT - 12'd1)) begin
          timeout_d = 1'b1;
          state_d   = bus_pkg::RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      bus_pkg::RELEASE: begin
        // Dead turnaround cycle: requests are not sampled here
        sid_d     = '0;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = bus_pkg::IDLE;
      end

      default: begin
        state_d = bus_pkg::IDLE;
      end
    endcase

    m1_grant_d  = ((state_d == bus_pkg::SID) || (state_d == bus_pkg::CONNECT)) && !msel_d;
    m2_grant_d  = ((state_d == bus_pkg::SID) || (state_d == bus_pkg::CONNECT)) && msel_d;
    slave_sel_d = (state_d == bus_pkg::CONNECT) ? (SEL_W'(1) << sid_d) : '0;
    bus_busy_d  = (state_d != bus_pkg::IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= bus_pkg::IDLE;
      sid_q       <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      m1_grant_q  <= 1'b0;
      m2_grant_q  <= 1'b0;
      msel_q      <= 1'b0;
      slave_sel_q <= '0;
      bus_busy_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sid_q       <= sid_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      m1_grant_q  <= m1_grant_d;
      m2_grant_q  <= m2_grant_d;
      msel_q      <= msel_d;
      slave_sel_q <= slave_sel_d;
      bus_busy_q  <= bus_busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign m1_grant  = m1_grant_q;
  assign m2_grant  = m2_grant_q;
  assign msel      = msel_q;
  assign slave_sel = slave_sel_q;
  assign bus_busy  = bus_busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (owner / ID bits collected / connect age).
module tb_bus_arbiter;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m1_req = 1'b0;
  logic       m2_req = 1'b0;
  logic       m_sid = 1'b0;
  logic       m_sid_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic       m1_grant;
  logic       m2_grant;
  logic       msel;
  logic [3:0] slave_sel;
  logic       bus_busy;
  logic       timeout;

  bus_arbiter #(.SLAVE_ID_W(2), .TIMEOUT(12'd8)) dut (
    .clk        (clk),
    .reset      (reset),
    .m1_req     (m1_req),
    .m2_req     (m2_req),
    .m_sid      (m_sid),
    .m_sid_valid(m_sid_valid),
    .tx_done    (tx_done),
    .m1_grant   (m1_grant),
    .m2_grant   (m2_grant),
    .msel       (msel),
    .slave_sel  (slave_sel),
    .bus_busy   (bus_busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, how many ID bits arrived,
  // how long the connection has lasted, and whether we are in the dead cycle.
  int mdl_owner = 0;      // 0 none, 1 master 1, 2 master 2
  int mdl_last  = 2;
  int mdl_win   = 0;
  int mdl_bits  = 0;
  int mdl_sid   = 0;
  int mdl_age   = 0;
  bit mdl_conn  = 1'b0;
  bit mdl_dead  = 1'b0;
  bit mdl_to    = 1'b0;
  bit mdl_msel  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_owner = 0; mdl_last = 2; mdl_bits = 0; mdl_sid = 0; mdl_age = 0;
      mdl_conn = 1'b0; mdl_dead = 1'b0; mdl_to = 1'b0; mdl_msel = 1'b0;
    end else begin
      mdl_to = 1'b0;
      if (mdl_dead) begin
        mdl_dead = 1'b0;
      end else if (mdl_owner == 0) begin
        if (m1_req || m2_req) begin
          if (m1_req && m2_req) mdl_win = (mdl_last == 1) ? 2 : 1;
          else                  mdl_win = m1_req ? 1 : 2;
          mdl_owner = mdl_win;
          mdl_last  = mdl_win;
          mdl_msel  = (mdl_win == 2);
          mdl_bits  = 0;
          mdl_sid   = 0;
        end
      end else if (!mdl_conn) begin
        if (!((mdl_owner == 1) ? m1_req : m2_req)) begin
          mdl_owner = 0;
        end else if (m_sid_valid) begin
          mdl_sid  = mdl_sid + (int'(m_sid) << mdl_bits);
          mdl_bits = mdl_bits + 1;
          if (mdl_bits == 2) begin
            mdl_conn = 1'b1;
            mdl_age  = 0;
          end
        end
      end else begin
        mdl_age = mdl_age + 1;
        if (tx_done || mdl_age == TMO) begin
          mdl_to    = !tx_done;
          mdl_conn  = 1'b0;
          mdl_owner = 0;
          mdl_dead  = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_m1_grant",  int'(m1_grant),  int'(mdl_owner == 1));
      chk("cmp_m2_grant",  int'(m2_grant),  int'(mdl_owner == 2));
      chk("cmp_msel",      int'(msel),      int'(mdl_msel));
      chk("cmp_slave_sel", int'(slave_sel), mdl_conn ? (1 << mdl_sid) : 0);
      chk("cmp_bus_busy",  int'(bus_busy),  int'((mdl_owner != 0) || mdl_dead));
      chk("cmp_timeout",   int'(timeout),   int'(mdl_to));
    end
  end

  // Drive one cycle of inputs at a falling edge, return at the next one
  task automatic cyc(input bit r1, input bit r2, input bit sid, input bit sv, input bit td);
    m1_req = r1; m2_req = r2; m_sid = sid; m_sid_valid = sv; tx_done = td;
    @(negedge clk);
  endtask

  int exp_order[3] = '{1, 2, 1};
  int n;
  bit rr1, rr2;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_m1_grant",  int'(m1_grant),  0);
    chk("rst_bus_busy",  int'(bus_busy),  0);
    chk("rst_slave_sel", int'(slave_sel), 0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Single request: one-cycle grant latency
    cyc(1, 0, 0, 0, 0);
    chk("single_m1_grant", int'(m1_grant), 1);
    chk("single_m2_grant", int'(m2_grant), 0);
    chk("single_msel",     int'(msel),     0);
    chk("single_busy",     int'(bus_busy), 1);

    // ID = 1 sent LSB-first as bits 1,0, then tx_done
    cyc(1, 0, 1, 1, 0);
    chk("id_mid_sel", int'(slave_sel), 0);
    cyc(1, 0, 0, 1, 0);
    chk("id1_sel", int'(slave_sel), 2);
    cyc(1, 0, 0, 0, 1);
    chk("rel_m1_grant", int'(m1_grant),  0);
    chk("rel_sel",      int'(slave_sel), 0);
    chk("rel_busy",     int'(bus_busy),  1);
    chk("rel_timeout",  int'(timeout),   0);
    cyc(0, 0, 0, 0, 0);
    chk("idle_busy", int'(bus_busy), 0);

    // Fairness with both requests held
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      cyc(1, 1, 0, 0, 0);
      chk("rr_m1_grant", int'(m1_grant), int'(exp_order[t] == 1));
      chk("rr_m2_grant", int'(m2_grant), int'(exp_order[t] == 2));
      cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 1, 1, 0);
      chk("rr_sel", int'(slave_sel), 8);
      cyc(1, 1, 0, 0, 1);
      chk("rr_rel_grants", int'({m1_grant, m2_grant}), 0);
      cyc(1, 1, 0, 0, 0);
      chk("rr_dead_grants", int'({m1_grant, m2_grant}), 0);
    end
    cyc(0, 0, 0, 0, 0);

    // Timeout: master 2, ID 3, no tx_done
    cyc(0, 1, 0, 0, 0);
    chk("to_m2_grant", int'(m2_grant), 1);
    chk("to_msel",     int'(msel),     1);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    n = 0;
    while (slave_sel == 4'b1000 && n < 20) begin
      n++;
      cyc(0, 1, 0, 0, 0);
    end
    chk("to_connect_cycles", n, 8);
    chk("to_pulse",          int'(timeout),  1);
    chk("to_m2_grant_drop",  int'(m2_grant), 0);
    cyc(0, 0, 0, 0, 0);
    chk("to_pulse_end", int'(timeout), 0);

    // Abort: request dropped after one ID bit
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("abort_grant", int'(m1_grant),  0);
    chk("abort_sel",   int'(slave_sel), 0);
    chk("abort_busy",  int'(bus_busy),  0);

    // Async reset in the middle of CONNECT
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 0);
    chk("pre_rst_sel", int'(slave_sel), 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_outputs", int'({m1_grant, m2_grant, msel, slave_sel, bus_busy, timeout}), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 1, 0, 0, 0);
    chk("post_rst_m2_grant", int'(m2_grant), 1);
    chk("post_rst_msel",     int'(msel),     1);
    cyc(0, 0, 0, 0, 0);

    // Randomized traffic, checked by the model every cycle
    rr1 = 1'b0;
    rr2 = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) rr1 = ~rr1;
      if ($urandom_range(0, 11) == 0) rr2 = ~rr2;
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      cyc(rr1, rr2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
